keypad_scan_ctrl: RTL and testbench

Parametrised matrix-keypad scan controller with integrated debounce, key encoding and N-key lockout. It drives one column at a time, samples the synchronised rows and debounces both press and release. Each accepted key is reported as a registered row/column code with a one-cycle valid strobe. It sits between the keypad pins and the key-handling / display logic, and replaces the fixed 4x4 scanner plus its external debounce counter.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/keypad_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scan controller.
package keypad_pkg;

    // Widest row vector the helper functions accept; narrower vectors are zero-extended.
    localparam int MAX_LINES = 32;

    typedef enum logic [2:0] {
        SETTLE,
        SAMPLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } scan_state_t;

    // Index of the least-significant set bit (0 when the vector is empty).
    function automatic int lowest_set_idx(input logic [MAX_LINES-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_LINES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    // True when at least two bits are set: clearing the lowest set bit leaves something behind.
    function automatic logic popcount_gt1(input logic [MAX_LINES-1:0] vec);
        return (vec & (vec - MAX_LINES'(1))) != '0;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous level inputs.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // First stage may go metastable; second stage gives it a full cycle to resolve.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix-keypad scanner: drives one column at a time, debounces press and
// release of the first key seen, reports it as a row/column code and locks
// out every other key until that one has been released.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int NROWS           = 4,
    parameter int NCOLS           = 4,
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NROWS-1:0]           rows,
    output logic [NCOLS-1:0]           cols,
    output logic                       key_valid,
    output logic [$clog2(NROWS)-1:0]   key_row,
    output logic [$clog2(NCOLS)-1:0]   key_col,
    output logic                       key_held,
    output logic                       multi_err
);

    localparam int ROW_W   = $clog2(NROWS);
    localparam int COL_W   = $clog2(NCOLS);
    localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(NCOLS - 1);

    scan_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [COL_W-1:0]     col_idx_q, col_idx_d;
    logic [COL_W-1:0]     col_inc;
    logic [NCOLS-1:0]     cols_q, cols_d;
    logic [NROWS-1:0]     row_snap_q, row_snap_d;
    logic [ROW_W-1:0]     key_row_q, key_row_d;
    logic [COL_W-1:0]     key_col_q, key_col_d;
    logic                 key_valid_q, key_valid_d;
    logic                 key_held_q, key_held_d;
    logic                 multi_err_q, multi_err_d;

    logic [NROWS-1:0]     rows_s;
    logic [MAX_LINES-1:0] rows_s_ext;
    logic [MAX_LINES-1:0] row_snap_ext;

    sync_2ff #(
        .W (NROWS)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rows),
        .q_o   (rows_s)
    );

    assign rows_s_ext   = MAX_LINES'(rows_s);
    assign row_snap_ext = MAX_LINES'(row_snap_q);

    // Next column index, wrapping after the last column.
    assign col_inc = (col_idx_q == COL_LAST) ? '0 : col_idx_q + COL_W'(1);

    // One-hot decode of the next column index so the column drive is itself a register.
    for (genvar gi = 0; gi < NCOLS; gi++) begin : g_col_decode
        assign cols_d[gi] = (col_idx_d == COL_W'(gi));
    end

    // Scan / debounce / lockout sequencing and next values of the output registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_idx_d   = col_idx_q;
        row_snap_d  = row_snap_q;
        key_row_d   = key_row_q;
        key_col_d   = key_col_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        multi_err_d = 1'b0;

        case (state_q)
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SAMPLE: begin
                cnt_d       = '0;
                multi_err_d = popcount_gt1(rows_s_ext);
                if (rows_s == '0) begin
                    col_idx_d = col_inc;
                    state_d   = SETTLE;
                end else begin
                    row_snap_d = rows_s;
                    state_d    = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (rows_s != row_snap_q) begin
                    // Any change of the row pattern restarts the scan on the next column.
                    col_idx_d = col_inc;
                    state_d   = SETTLE;
                    cnt_d     = '0;
                end else if (cnt_q == DEBOUNCE_LAST) begin
                    key_row_d   = ROW_W'(lowest_set_idx(row_snap_ext));
                    key_col_d   = col_idx_q;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = HELD;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HELD: begin
                // Only the accepted row is watched; other rows on this column are ignored.
                cnt_d = '0;
                if (!rows_s[key_row_q]) begin
                    state_d = RELEASE;
                end
            end

            RELEASE: begin
                if (rows_s[key_row_q]) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEBOUNCE_LAST) begin
                    col_idx_d  = col_inc;
                    key_held_d = 1'b0;
                    state_d    = SETTLE;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state, shared counter, column index and row snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SETTLE;
            cnt_q      <= '0;
            col_idx_q  <= '0;
            row_snap_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            col_idx_q  <= col_idx_d;
            row_snap_q <= row_snap_d;
        end
    end

    // Registered outputs; reset clears a pending key so it can never be reported later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cols_q      <= NCOLS'(1);
            key_row_q   <= '0;
            key_col_q   <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            cols_q      <= cols_d;
            key_row_q   <= key_row_d;
            key_col_q   <= key_col_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            multi_err_q <= multi_err_d;
        end
    end

    assign cols      = cols_q;
    assign key_row   = key_row_q;
    assign key_col   = key_col_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign multi_err = multi_err_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad model drives rows from the active
// column, and expected timing comes from the scan arithmetic (each column
// lasts S+1 cycles, debounce and release each take D cycles).
module tb_keypad_scan_ctrl;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int S  = 2;
    localparam int D  = 8;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [NR-1:0] rows  = '0;
    logic [NC-1:0] cols;
    logic          key_valid;
    logic [1:0]    key_row;
    logic [1:0]    key_col;
    logic          key_held;
    logic          multi_err;

    keypad_scan_ctrl #(
        .NROWS           (NR),
        .NCOLS           (NC),
        .SETTLE_CYCLES   (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_valid (key_valid),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_held  (key_held),
        .multi_err (multi_err)
    );

    always #5 clk = ~clk;

    // Keypad: mask[c] holds the rows closed on column c.
    logic [NR-1:0] mask [NC];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcount = 0;
    int mcount = 0;
    int last_v_cyc = -1;
    int last_m_cyc = -1;
    int last_row = -1;
    int last_col = -1;
    int scan_col = 0;   // column the scanner is known to start at scan_cyc
    int scan_cyc = 0;

    typedef struct {
        int            col;
        logic [NR-1:0] mask;
        int            exp_row;
        int            exp_multi;
        int            hold;
    } vec_t;
    vec_t tbl [5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_rows();
        logic [NR-1:0] r;
        r = '0;
        for (int c = 0; c < NC; c++) begin
            if (cols[c]) r = r | mask[c];
        end
        rows = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (key_valid) begin
            vcount++;
            last_v_cyc = cyc;
            last_row = int'(key_row);
            last_col = int'(key_col);
        end
        if (multi_err) begin
            mcount++;
            last_m_cyc = cyc;
        end
        set_rows();
    endtask

    task automatic release_reset();
        reset = 1'b1;
        cyc = 0;
        vcount = 0;
        mcount = 0;
        last_v_cyc = -1;
        last_m_cyc = -1;
        last_row = -1;
        last_col = -1;
        scan_col = 0;
        scan_cyc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < NC; c++) mask[c] = '0;
        #1;
        set_rows();
        check("rst_cols", int'(cols), 1);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_multi", int'(multi_err), 0);
        check("rst_key", int'({key_row, key_col}), 0);
        @(negedge clk);
        @(negedge clk);
        release_reset();
    endtask

    function automatic int ref_lowest(input logic [NR-1:0] m);
        for (int i = 0; i < NR; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    // Press one key when the scanner is at a column start, wait for it, hold, release.
    task automatic run_key(input int c, input logic [NR-1:0] m, input int exp_row,
                           input int exp_multi, input int hold);
        int v0, m0, exp_v, r;
        bit frozen_ok;
        v0 = vcount;
        m0 = mcount;
        exp_v = scan_cyc + ((c - scan_col + NC) % NC) * (S + 1) + (S + 1) + D;
        mask[c] = m;
        set_rows();
        for (int i = 0; i < 200 && vcount == v0; i++) tick();
        $display("key col=%0d mask=%b -> valid at cyc %0d row=%0d col=%0d", c, m,
                 (vcount == v0) ? -1 : last_v_cyc, last_row, last_col);
        check("valid_cyc", (vcount == v0) ? -1 : last_v_cyc, exp_v);
        check("key_row", last_row, exp_row);
        check("key_col", last_col, c);
        check("multi_cnt", mcount - m0, exp_multi);
        if (exp_multi != 0) check("multi_cyc", last_m_cyc, exp_v - D);
        check("held_on", int'(key_held), 1);
        frozen_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (int'(cols) != (1 << c) || !key_held) frozen_ok = 1'b0;
        end
        check("frozen", int'(frozen_ok), 1);
        mask[c] = '0;
        set_rows();
        r = cyc;
        while (cyc < r + D + 2) tick();
        check("held_release", int'(key_held), 1);
        check("cols_release", int'(cols), 1 << c);
        tick();
        check("held_off", int'(key_held), 0);
        check("cols_resume", int'(cols), 1 << ((c + 1) % NC));
        check("one_valid", vcount - v0, 1);
        scan_col = (c + 1) % NC;
        scan_cyc = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        bit ok;

        tbl[0] = '{col: 1, mask: 4'b0100, exp_row: 2, exp_multi: 0, hold: 40};
        tbl[1] = '{col: 3, mask: 4'b0101, exp_row: 0, exp_multi: 1, hold: 10};
        tbl[2] = '{col: 0, mask: 4'b1000, exp_row: 3, exp_multi: 0, hold: 5};
        tbl[3] = '{col: 2, mask: 4'b0110, exp_row: 1, exp_multi: 1, hold: 0};
        tbl[4] = '{col: 0, mask: 4'b1111, exp_row: 0, exp_multi: 1, hold: 12};

        // Idle scan: three cycles per column, nothing reported.
        do_reset();
        check("idle_cols", int'(cols), 1);
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("idle_cols", int'(cols), 1 << ((k / (S + 1)) % NC));
        end
        check("idle_valid", vcount, 0);
        check("idle_multi", mcount, 0);
        check("idle_held", int'(key_held), 0);

        // Table-driven single-key transactions, each from reset.
        for (int t = 0; t < 5; t++) begin
            do_reset();
            run_key(tbl[t].col, tbl[t].mask, tbl[t].exp_row, tbl[t].exp_multi, tbl[t].hold);
        end

        // Bounce: row 0 / col 2 chatters, then settles; exactly one key.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            mask[2] = (((i / 3) % 2) == 0) ? 4'b0001 : 4'b0000;
            set_rows();
            tick();
        end
        check("bounce_none", vcount, 0);
        mask[2] = 4'b0001;
        set_rows();
        repeat (80) tick();
        $display("bounce -> %0d valid, row=%0d col=%0d", vcount, last_row, last_col);
        check("bounce_count", vcount, 1);
        check("bounce_row", last_row, 0);
        check("bounce_col", last_col, 2);

        // Lockout: second key on another column is invisible until the first releases.
        do_reset();
        mask[0] = 4'b0010;
        set_rows();
        for (int i = 0; i < 60 && vcount == 0; i++) tick();
        check("lock_first_cyc", last_v_cyc, (S + 1) + D);
        check("lock_first_key", last_row * 4 + last_col, 1 * 4 + 0);
        mask[2] = 4'b1000;
        set_rows();
        ok = 1'b1;
        repeat (30) begin
            tick();
            if (int'(cols) != 1) ok = 1'b0;
        end
        check("lock_frozen", int'(ok), 1);
        check("lock_single", vcount, 1);
        mask[0] = 4'b0000;
        set_rows();
        r = cyc;
        for (int i = 0; i < 100 && vcount == 1; i++) tick();
        $display("lockout second key -> valid at cyc %0d row=%0d col=%0d", last_v_cyc, last_row, last_col);
        check("lock_second_cyc", last_v_cyc, r + 3 + D + 2 * (S + 1) + D);
        check("lock_second_key", last_row * 4 + last_col, 3 * 4 + 2);
        check("lock_second_cols", int'(cols), 4'b0100);

        // Short release glitch is absorbed by the release debounce.
        do_reset();
        mask[1] = 4'b0100;
        set_rows();
        for (int i = 0; i < 60 && vcount == 0; i++) tick();
        check("glitch_first", vcount, 1);
        mask[1] = 4'b0000;
        set_rows();
        repeat (4) tick();
        mask[1] = 4'b0100;
        set_rows();
        repeat (20) tick();
        check("glitch_held", int'(key_held), 1);
        check("glitch_cols", int'(cols), 4'b0010);
        check("glitch_once", vcount, 1);

        // Reset during debounce discards the key.
        do_reset();
        mask[1] = 4'b0100;
        set_rows();
        repeat (9) tick();
        reset = 1'b0;
        #1;
        check("mid_deb_cols", int'(cols), 1);
        check("mid_deb_valid", int'(key_valid), 0);
        check("mid_deb_held", int'(key_held), 0);
        mask[1] = 4'b0000;
        set_rows();
        @(negedge clk);
        @(negedge clk);
        release_reset();
        repeat (40) tick();
        check("mid_deb_no_valid", vcount, 0);

        // Reset while a key is held clears the reported code at once.
        do_reset();
        mask[1] = 4'b0100;
        set_rows();
        repeat (20) tick();
        check("pre_held", int'(key_held), 1);
        check("pre_key", last_row * 4 + last_col, 2 * 4 + 1);
        reset = 1'b0;
        #1;
        check("mid_held_held", int'(key_held), 0);
        check("mid_held_key", int'({key_row, key_col}), 0);
        check("mid_held_cols", int'(cols), 1);
        mask[1] = 4'b0000;
        set_rows();
        @(negedge clk);
        @(negedge clk);
        release_reset();
        repeat (40) tick();
        check("mid_held_no_valid", vcount, 0);

        // Random chained key sequence against the scan-arithmetic model.
        do_reset();
        for (int it = 0; it < 20; it++) begin
            int c, g, hold;
            logic [NR-1:0] m;
            g = int'($urandom_range(0, 5));
            ok = 1'b1;
            for (int i = 0; i < g * (S + 1); i++) begin
                tick();
                if (int'(cols) != (1 << ((scan_col + (cyc - scan_cyc) / (S + 1)) % NC))) ok = 1'b0;
            end
            check("gap_scan", int'(ok), 1);
            scan_col = (scan_col + g) % NC;
            scan_cyc = cyc;
            c = int'($urandom_range(0, NC - 1));
            m = NR'($urandom_range(1, (1 << NR) - 1));
            hold = int'($urandom_range(0, 15));
            run_key(c, m, ref_lowest(m), ($countones(m) > 1) ? 1 : 0, hold);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
